// File: rtl/piarb_qdepth_pkg.sv
// Shared types and sizing for the PU queue depth tracker.
// Ack bundle is reused by piarb_sch-style initiators.
package piarb_qdepth_pkg;

  localparam int NUM_OF_PU = 32;
  localparam int PU_QUEUE_ENTRIES_NBITS = 6;
  localparam int QID_NBITS = 5;

  typedef struct packed {
    logic                 ack;
    logic                 flag;
    logic [QID_NBITS-1:0] qid;
  } ack_t;

endpackage

// File: rtl/piarb_qdepth_cnt.sv
// Single saturating queue depth counter.
// Dequeue is applied before enqueue; value is the pre-update depth.
module piarb_qdepth_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] mid;
  logic [W-1:0] cnt_d;

  always_comb begin
    mid = cnt_q;
    if (dec && (cnt_q != '0)) mid = cnt_q - 1'b1;
    cnt_d = mid;
    if (inc && (mid != MAX)) cnt_d = mid + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/piarb_qdepth.sv
// Per-PU queue depth tracker answering enqueue/dequeue requests
// with registered acks and scheduling hints.
module piarb_qdepth
  import piarb_qdepth_pkg::*;
#(
  parameter int QUEUE_ID_NBITS      = QID_NBITS,
  parameter int QUEUE_DEPTH         = NUM_OF_PU,
  parameter int QUEUE_ENTRIES_NBITS = PU_QUEUE_ENTRIES_NBITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_req,
  input  logic [QUEUE_ID_NBITS-1:0] enq_qid,
  input  logic                      deq_req,
  input  logic [QUEUE_ID_NBITS-1:0] deq_qid,
  output logic                      enq_ack,
  output logic                      enq_to_empty,
  output logic [QUEUE_ID_NBITS-1:0] enq_ack_qid,
  output logic                      deq_depth_ack,
  output logic                      deq_depth_from_emptyp2,
  output logic                      enq_ovf,
  output logic                      deq_udf
);

  localparam int W = QUEUE_ENTRIES_NBITS;
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [QUEUE_DEPTH-1:0] inc_v;
  logic [QUEUE_DEPTH-1:0] dec_v;
  logic [W-1:0]           depth [QUEUE_DEPTH];

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      inc_v[i] = enq_req && (enq_qid == QUEUE_ID_NBITS'(i));
      dec_v[i] = deq_req && (deq_qid == QUEUE_ID_NBITS'(i));
    end
  end

  for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_cnt
    piarb_qdepth_cnt #(.W(W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_v[g]),
      .dec   (dec_v[g]),
      .value (depth[g])
    );
  end

  logic [W-1:0] d_enq;
  logic [W-1:0] d_deq;
  logic [W-1:0] e_enq;
  logic         same_q;

  // A same-cycle dequeue to the same queue is ordered first.
  always_comb begin
    d_enq  = depth[enq_qid];
    d_deq  = depth[deq_qid];
    same_q = enq_req && deq_req && (enq_qid == deq_qid);
    e_enq  = d_enq;
    if (same_q && (d_enq != '0)) e_enq = d_enq - 1'b1;
  end

  ack_t enq_r;
  logic deq_ack_r;
  logic deq_flag_r;
  logic ovf_r;
  logic udf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_r      <= '0;
      deq_ack_r  <= 1'b0;
      deq_flag_r <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      enq_r.ack  <= enq_req;
      enq_r.flag <= enq_req && (e_enq == '0);
      enq_r.qid  <= enq_req ? enq_qid : '0;
      deq_ack_r  <= deq_req;
      deq_flag_r <= deq_req && (d_deq > W'(1));
      ovf_r      <= ovf_r | (enq_req && (e_enq == MAX));
      udf_r      <= udf_r | (deq_req && (d_deq == '0));
    end
  end

  assign enq_ack                = enq_r.ack;
  assign enq_to_empty           = enq_r.flag;
  assign enq_ack_qid            = enq_r.qid;
  assign deq_depth_ack          = deq_ack_r;
  assign deq_depth_from_emptyp2 = deq_flag_r;
  assign enq_ovf                = ovf_r;
  assign deq_udf                = udf_r;

endmodule

// File: tb/tb_piarb_qdepth.sv
// Directed self-checking bench for piarb_qdepth.
module tb_piarb_qdepth;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enq_req = 1'b0;
  logic [4:0] enq_qid = '0;
  logic       deq_req = 1'b0;
  logic [4:0] deq_qid = '0;
  logic       enq_ack, enq_to_empty, deq_depth_ack;
  logic       deq_depth_from_emptyp2, enq_ovf, deq_udf;
  logic [4:0] enq_ack_qid;

  int checks = 0;
  int errors = 0;

  piarb_qdepth dut (
    .clk                    (clk),
    .rst                    (rst),
    .enq_req                (enq_req),
    .enq_qid                (enq_qid),
    .deq_req                (deq_req),
    .deq_qid                (deq_qid),
    .enq_ack                (enq_ack),
    .enq_to_empty           (enq_to_empty),
    .enq_ack_qid            (enq_ack_qid),
    .deq_depth_ack          (deq_depth_ack),
    .deq_depth_from_emptyp2 (deq_depth_from_emptyp2),
    .enq_ovf                (enq_ovf),
    .deq_udf                (deq_udf)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic e, input logic [4:0] eq,
                     input logic d, input logic [4:0] dq);
    enq_req = e; enq_qid = eq;
    deq_req = d; deq_qid = dq;
    @(posedge clk); #1;
    enq_req = 1'b0; deq_req = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    checks++;
    if ({enq_ack, enq_to_empty, enq_ack_qid, deq_depth_ack,
         deq_depth_from_emptyp2, enq_ovf, deq_udf} !== 11'd0) begin
      errors++;
      $display("FAIL %s outputs got %b exp 0", tag,
               {enq_ack, enq_to_empty, enq_ack_qid, deq_depth_ack,
                deq_depth_from_emptyp2, enq_ovf, deq_udf});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk_all_zero("idle_after_reset");
  endtask

  task automatic test_enq_first();
    cyc(1, 3, 0, 0);
    chk("enq3_ack", 8'(enq_ack), 8'd1);
    chk("enq3_qid", 8'(enq_ack_qid), 8'd3);
    chk("enq3_to_empty", 8'(enq_to_empty), 8'd1);
    cyc(1, 3, 0, 0);
    chk("enq3b_ack", 8'(enq_ack), 8'd1);
    chk("enq3b_to_empty", 8'(enq_to_empty), 8'd0);
    cyc(0, 0, 0, 0);
    chk("strobe_single", 8'(enq_ack), 8'd0);
    chk("qid_held0", 8'(enq_ack_qid), 8'd0);
    cyc(0, 0, 1, 3);
    chk("deq3_d2_flag", 8'(deq_depth_from_emptyp2), 8'd1);
    cyc(0, 0, 1, 3);
    chk("deq3_d1_flag", 8'(deq_depth_from_emptyp2), 8'd0);
    chk("no_udf", 8'(deq_udf), 8'd0);
  endtask

  task automatic test_deq_twice();
    cyc(1, 5, 0, 0);
    cyc(1, 5, 0, 0);
    cyc(0, 0, 1, 5);
    chk("deq5a_ack", 8'(deq_depth_ack), 8'd1);
    chk("deq5a_flag", 8'(deq_depth_from_emptyp2), 8'd1);
    cyc(0, 0, 1, 5);
    chk("deq5b_ack", 8'(deq_depth_ack), 8'd1);
    chk("deq5b_flag", 8'(deq_depth_from_emptyp2), 8'd0);
    cyc(1, 5, 0, 0);
    chk("q5_empty_again", 8'(enq_to_empty), 8'd1);
    cyc(0, 0, 1, 5);
    chk("q5_udf_clear", 8'(deq_udf), 8'd0);
  endtask

  task automatic test_same_qid();
    cyc(1, 7, 0, 0);
    cyc(1, 7, 1, 7);
    chk("same_deq_ack", 8'(deq_depth_ack), 8'd1);
    chk("same_deq_flag", 8'(deq_depth_from_emptyp2), 8'd0);
    chk("same_enq_ack", 8'(enq_ack), 8'd1);
    chk("same_enq_to_empty", 8'(enq_to_empty), 8'd1);
    chk("same_qid", 8'(enq_ack_qid), 8'd7);
    cyc(0, 0, 1, 7);
    chk("q7_depth1", 8'(deq_depth_from_emptyp2), 8'd0);
    chk("q7_no_udf", 8'(deq_udf), 8'd0);
  endtask

  task automatic test_diff_qid();
    cyc(1, 10, 0, 0);
    cyc(1, 10, 0, 0);
    cyc(1, 9, 1, 10);
    chk("diff_enq_to_empty", 8'(enq_to_empty), 8'd1);
    chk("diff_enq_qid", 8'(enq_ack_qid), 8'd9);
    chk("diff_deq_flag", 8'(deq_depth_from_emptyp2), 8'd1);
    cyc(0, 0, 1, 10);
    chk("q10_depth1", 8'(deq_depth_from_emptyp2), 8'd0);
  endtask

  task automatic test_underflow();
    cyc(0, 0, 1, 0);
    chk("udf_ack", 8'(deq_depth_ack), 8'd1);
    chk("udf_flag", 8'(deq_depth_from_emptyp2), 8'd0);
    chk("udf_set", 8'(deq_udf), 8'd1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("udf_sticky", 8'(deq_udf), 8'd1);
    cyc(1, 0, 0, 0);
    chk("q0_stays0", 8'(enq_to_empty), 8'd1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 63; i++) cyc(1, 31, 0, 0);
    chk("fill_no_ovf", 8'(enq_ovf), 8'd0);
    chk("fill_last_to_empty", 8'(enq_to_empty), 8'd0);
    cyc(1, 31, 0, 0);
    chk("ovf_ack", 8'(enq_ack), 8'd1);
    chk("ovf_to_empty", 8'(enq_to_empty), 8'd0);
    chk("ovf_set", 8'(enq_ovf), 8'd1);
    cyc(1, 31, 1, 31);
    chk("full_same_flag", 8'(deq_depth_from_emptyp2), 8'd1);
    chk("full_same_to_empty", 8'(enq_to_empty), 8'd0);
    for (int i = 0; i < 62; i++) cyc(0, 0, 1, 31);
    chk("drain62_flag", 8'(deq_depth_from_emptyp2), 8'd1);
    cyc(0, 0, 1, 31);
    chk("drain63_flag", 8'(deq_depth_from_emptyp2), 8'd0);
    cyc(1, 31, 0, 0);
    chk("q31_empty", 8'(enq_to_empty), 8'd1);
    chk("ovf_sticky", 8'(enq_ovf), 8'd1);
  endtask

  task automatic test_reset_mid();
    cyc(1, 3, 0, 0);
    cyc(1, 3, 0, 0);
    enq_req = 1'b1; enq_qid = 5'd3;
    deq_req = 1'b1; deq_qid = 5'd3;
    @(posedge clk); #1;
    chk("pre_rst_ack", 8'(enq_ack), 8'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    enq_req = 1'b0; deq_req = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid_reset_hold");
    rst = 1'b0;
    cyc(1, 3, 0, 0);
    chk("post_rst_to_empty", 8'(enq_to_empty), 8'd1);
    chk("post_rst_qid", 8'(enq_ack_qid), 8'd3);
    chk("post_rst_ovf", 8'(enq_ovf), 8'd0);
    chk("post_rst_udf", 8'(deq_udf), 8'd0);
  endtask

  initial begin
    test_reset();
    test_enq_first();
    test_deq_twice();
    test_same_qid();
    test_diff_qid();
    test_underflow();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
